pipeline_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    FAULT    = 2'd3
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_q <= '0;
    else if (inc && (count_q != {CNT_W{1'b1}}))
      count_q <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencing: boot hold, load-use interlock, redirect flush,
// data-memory wait with timeout fault, plus saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic [4:0]       idex_rd,
  input  logic             idex_memread,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             back_write,
  output logic             fault,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   boot_q, boot_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic            load_use;
  logic            run_rules;

  assign load_use = idex_memread && (idex_rd != REG_ZERO) &&
                    ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      boot_q  <= BW'(BOOT_CYCLES - 1);
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_d     = boot_q;
    wait_d     = wait_q;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ifid_write = 1'b0;
    ifid_flush = 1'b0;
    idex_write = 1'b0;
    idex_flush = 1'b0;
    back_write = 1'b0;
    run_rules  = 1'b0;

    case (state_q)
      BOOT: begin
        ifid_flush = 1'b1;
        idex_write = 1'b1;
        idex_flush = 1'b1;
        back_write = 1'b1;
        if (boot_q == '0) state_d = RUN;
        else              boot_d  = boot_q - BW'(1);
      end
      RUN: run_rules = 1'b1;
      MEM_WAIT: begin
        // wait_q holds the busy cycles still allowed before the fault edge
        if (mem_busy) begin
          if (wait_q == '0) state_d = FAULT;
          else              wait_d  = wait_q - TW'(1);
        end else begin
          state_d   = RUN;
          run_rules = 1'b1;
        end
      end
      default: ;
    endcase

    if (run_rules) begin
      if (mem_busy) begin
        state_d = MEM_WAIT;
        wait_d  = TW'(MEM_TIMEOUT - 2);
      end else if (ex_redirect) begin
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        idex_write = 1'b1;
        idex_flush = 1'b1;
        back_write = 1'b1;
      end else if (load_use) begin
        idex_write = 1'b1;
        idex_flush = 1'b1;
        back_write = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        idex_write = 1'b1;
        back_write = 1'b1;
      end
    end
  end

  assign fault = (state_q == FAULT);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (((state_q == RUN) || (state_q == MEM_WAIT)) && !pc_write),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_src),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, corner sequences and a random
// run against a rule-level model; a CNT_W=4 copy exercises saturation.
module tb_pipeline_hazard_ctrl;

  localparam int BOOT_CYCLES = 2;
  localparam int MEM_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
  logic        ifid_uses_rs2 = 1'b0, idex_memread = 1'b0, ex_redirect = 1'b0, mem_busy = 1'b0;

  logic        pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush, back_write, fault;
  logic [31:0] stall_cnt, flush_cnt;
  logic        pc_write4, pc_src4, ifid_write4, ifid_flush4, idex_write4, idex_flush4, back_write4, fault4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_memread(idex_memread), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_write(pc_write), .pc_src(pc_src), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush), .back_write(back_write), .fault(fault),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipeline_hazard_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
    .idex_rd(idex_rd), .idex_memread(idex_memread), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .pc_write(pc_write4), .pc_src(pc_src4), .ifid_write(ifid_write4), .ifid_flush(ifid_flush4),
    .idex_write(idex_write4), .idex_flush(idex_flush4), .back_write(back_write4), .fault(fault4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

  // bit order: pc_write pc_src ifid_write ifid_flush idex_write idex_flush back_write
  localparam logic [6:0] C_BOOT = 7'b0001111;
  localparam logic [6:0] C_FRZ  = 7'b0000000;
  localparam logic [6:0] C_REDR = 7'b1111111;
  localparam logic [6:0] C_LU   = 7'b0000111;
  localparam logic [6:0] C_ADV  = 7'b1010101;

  int total = 0;
  int bad   = 0;

  // model: cycles since reset, current busy streak, fault flag, unsaturated event totals
  int m_cyc, m_busy, m_stall, m_flush;
  bit m_fault;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [6:0] model_ctl();
    bit hazard;
    hazard = idex_memread && (idex_rd != 0) &&
             ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
    if (m_cyc < BOOT_CYCLES)      return C_BOOT;
    if (m_fault || mem_busy)      return C_FRZ;
    if (ex_redirect)              return C_REDR;
    if (hazard)                   return C_LU;
    return C_ADV;
  endfunction

  function automatic void model_edge(logic [6:0] c);
    if (m_cyc >= BOOT_CYCLES && !m_fault) begin
      if (!c[6]) m_stall++;
      if (c[5])  m_flush++;
      if (mem_busy) begin
        m_busy++;
        if (m_busy == MEM_TIMEOUT) m_fault = 1'b1;
      end else begin
        m_busy = 0;
      end
    end
    if (m_cyc < 1000000) m_cyc++;
  endfunction

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic mr, input logic rdr, input logic busy);
    ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_uses_rs2 = u2;
    idex_rd = rd; idex_memread = mr; ex_redirect = rdr; mem_busy = busy;
  endtask

  // Called ~1 time unit after a rising edge (or after reset release).
  task automatic cycle(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic mr, input logic rdr, input logic busy,
                       output logic [6:0] act);
    logic [6:0] exp;
    set_in(rs1, rs2, u2, rd, mr, rdr, busy);
    #2;
    exp = model_ctl();
    act = {pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush, back_write};
    chk("ctl", {25'd0, act}, {25'd0, exp});
    chk("ctl4", {25'd0, pc_write4, pc_src4, ifid_write4, ifid_flush4, idex_write4, idex_flush4, back_write4},
        {25'd0, exp});
    chk("fault", {31'd0, fault}, {31'd0, m_fault});
    chk("stall_cnt", stall_cnt, 32'(m_stall));
    chk("flush_cnt", flush_cnt, 32'(m_flush));
    chk("stall_cnt4", {28'd0, stall_cnt4}, 32'(sat(m_stall, 15)));
    chk("flush_cnt4", {28'd0, flush_cnt4}, 32'(sat(m_flush, 15)));
    @(posedge clk);
    model_edge(exp);
    #1;
  endtask

  task automatic idle(output logic [6:0] act);
    cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, act);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("rst_ctl", {25'd0, pc_write, pc_src, ifid_write, ifid_flush, idex_write, idex_flush, back_write},
        {25'd0, C_BOOT});
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_flush", flush_cnt, 32'd0);
    m_cyc = 0; m_busy = 0; m_stall = 0; m_flush = 0; m_fault = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u2;
    logic [4:0] rd;
    logic       mr, rdr;
    logic [6:0] exp;
  } vec_t;

  initial begin
    vec_t       vecs[8];
    logic [6:0] a;
    int         burst;

    vecs[0] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, C_LU};    // load-use via rs1
    vecs[1] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, C_ADV};   // rd=x0 never stalls
    vecs[2] = '{5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, C_REDR};  // redirect beats load-use
    vecs[3] = '{5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, C_LU};    // load-use via rs2
    vecs[4] = '{5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, C_ADV};   // rs2 not read
    vecs[5] = '{5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, C_ADV};   // not a load
    vecs[6] = '{5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, C_REDR};  // plain redirect
    vecs[7] = '{5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, C_ADV};   // no match

    // boot hold
    do_reset();
    idle(a); chk("boot0_pcw", {31'd0, a[6]}, 32'd0); chk("boot0_idf", {31'd0, a[1]}, 32'd1);
    idle(a); chk("boot1_pcw", {31'd0, a[6]}, 32'd0); chk("boot1_idf", {31'd0, a[1]}, 32'd1);
    idle(a); chk("boot2_pcw", {31'd0, a[6]}, 32'd1); chk("boot2_ifw", {31'd0, a[4]}, 32'd1);

    // table
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].rs1, vecs[i].rs2, vecs[i].u2, vecs[i].rd, vecs[i].mr, vecs[i].rdr, 1'b0, a);
      chk($sformatf("vec%0d", i), {25'd0, a}, {25'd0, vecs[i].exp});
    end

    // load-use stall then redirect counts from a clean start
    do_reset();
    idle(a); idle(a);
    cycle(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, a);
    idle(a); chk("lu_stall_cnt", stall_cnt, 32'd1);
    cycle(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, a);
    idle(a); chk("rd_flush_cnt", flush_cnt, 32'd1); chk("rd_stall_cnt", stall_cnt, 32'd1);

    // three busy cycles, redirect pending during the wait is held
    do_reset();
    idle(a); idle(a);
    for (int i = 0; i < 3; i++) begin
      cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, a);
      chk("busy_frz", {25'd0, a}, {25'd0, C_FRZ});
    end
    idle(a);
    chk("busy_stall_cnt", stall_cnt, 32'd3);
    chk("busy_release", {25'd0, a}, {25'd0, C_ADV});

    // timeout to fault, then reset out of it
    do_reset();
    idle(a); idle(a);
    for (int i = 0; i < MEM_TIMEOUT; i++) cycle(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, a);
    idle(a);
    chk("fault_set", {31'd0, fault}, 32'd1);
    chk("fault_frz", {25'd0, a}, {25'd0, C_FRZ});
    idle(a);
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    do_reset();

    // saturation in the 4-bit copy
    idle(a); idle(a);
    for (int i = 0; i < 20; i++) cycle(5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, a);
    idle(a);
    chk("sat_stall4", {28'd0, stall_cnt4}, 32'd15);
    chk("sat_stall32", stall_cnt, 32'd20);

    // random run
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      logic b;
      if ($urandom_range(0, 999) == 0) do_reset();
      if (burst == 0 && $urandom_range(0, 63) == 0) burst = $urandom_range(4, 20);
      b = (burst > 0) || ($urandom_range(0, 7) == 0);
      if (burst > 0) burst--;
      cycle(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), b, a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
